color_matrix_nxn: RTL and testbench

Parametrised N×N fixed-point colour/transformation matrix with per-output bias, round-half-up, saturation and a valid/ready stream interface. It succeeds the fixed 3×3 valid-only transform. It adds:
- backpressure;
- generic channel count;
- a bias vector;
- double-buffered coefficients that switch atomically at a start-of-frame beat.

It sits in the video pipeline between pixel unpacking and output packing.

---
 rtl/color_matrix_pkg.sv | 45 ++++
 rtl/color_matrix_nxn_row_dot.sv | 83 ++++++++
 rtl/color_matrix_nxn.sv | 135 +++++++++++++
 tb/tb_color_matrix_nxn.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_matrix_pkg.sv
// Shared width formulas and helpers for the N x N colour matrix.
package color_matrix_pkg;

    // Coefficient word width: integer bits (incl. sign) plus fractional bits.
    function automatic int calc_mdw(input int midw, input int mfdw);
        return midw + mfdw;
    endfunction

    // Right shift that maps the full-precision row sum back to output LSBs.
    function automatic int calc_shift(input int mfdw, input int idw, input int odw);
        return mfdw + idw - odw;
    endfunction

    // Product width: input zero-extended to idw+1 signed, times an mdw-bit coefficient.
    function automatic int calc_prodw(input int idw, input int mdw);
        return idw + 1 + mdw;
    endfunction

    // Row-sum width: growth for dim terms plus one guard bit, so no overflow is possible.
    function automatic int calc_sumw(input int idw, input int mdw, input int dim);
        return idw + 1 + mdw + $clog2(dim) + 1;
    endfunction

    // Identity coefficient: 1.0 on the diagonal, zero elsewhere.
    function automatic longint identity_coef(input int r, input int c, input int mfdw);
        return (r == c) ? (longint'(1) << mfdw) : longint'(0);
    endfunction

    // Half-LSB rounding constant added before the shift (zero when truncating).
    function automatic longint round_const(input int shift, input int rnd);
        return (rnd != 0 && shift > 0) ? (longint'(1) << (shift - 1)) : longint'(0);
    endfunction

    // Clamp a signed value to the unsigned range [0, 2^odw-1].
    function automatic longint sat_u(input longint v, input int odw);
        longint vmax;
        vmax = (longint'(1) << odw) - 1;
        if (v < 0)
            return 0;
        if (v > vmax)
            return vmax;
        return v;
    endfunction

endpackage

// File: rtl/color_matrix_nxn_row_dot.sv
// One output row of the colour matrix: multiply, sum, round/shift/bias/saturate.
module cm_row_dot
    import color_matrix_pkg::*;
#(
    parameter int DIM   = 3,
    parameter int IDW   = 10,
    parameter int MIDW  = 2,
    parameter int MFDW  = 14,
    parameter int ODW   = 8,
    parameter int ROUND = 1,
    localparam int MDW  = calc_mdw(MIDW, MFDW),
    localparam int BIW  = ODW + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en_i,
    input  logic [DIM*IDW-1:0]    din_i,
    input  logic [DIM*MDW-1:0]    coef_i,
    input  logic signed [BIW-1:0] bias_i,
    output logic [ODW-1:0]        dout_o
);

    localparam int SHIFT = calc_shift(MFDW, IDW, ODW);
    localparam int PW    = calc_prodw(IDW, MDW);
    localparam int SUMW  = calc_sumw(IDW, MDW, DIM);
    localparam int SHW   = SUMW - SHIFT;
    localparam int BW    = SHW + 1;
    localparam logic signed [SUMW-1:0] RND = SUMW'(round_const(SHIFT, ROUND));

    logic signed [PW-1:0]   prod_d [DIM];
    logic signed [PW-1:0]   prod_q [DIM];
    logic signed [BIW-1:0]  bias1_q, bias2_q;
    logic signed [SUMW-1:0] sum_d, sum_q;
    logic signed [SUMW-1:0] rnd_sum, shifted;
    logic signed [BW-1:0]   biased;
    logic [ODW-1:0]         dout_d, dout_q;

    // Stage 1 inputs: per-column signed products (input zero-extended to IDW+1).
    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            prod_d[c] = PW'($signed({1'b0, din_i[c*IDW +: IDW]})) *
                        PW'($signed(coef_i[c*MDW +: MDW]));
        end
    end

    // Stage 2 inputs: sign-extended row sum of the registered products.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < DIM; c++) begin
            sum_d = sum_d + SUMW'(prod_q[c]);
        end
    end

    // Stage 3 inputs: round, arithmetic shift, bias add one bit wider, then clamp.
    always_comb begin
        rnd_sum = sum_q + RND;
        shifted = rnd_sum >>> SHIFT;
        biased  = BW'(shifted) + BW'(bias2_q);
        dout_d  = ODW'(sat_u(longint'(biased), ODW));
    end

    // Pipeline registers; the whole row holds when the stream is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < DIM; c++) begin
                prod_q[c] <= '0;
            end
            bias1_q <= '0;
            sum_q   <= '0;
            bias2_q <= '0;
            dout_q  <= '0;
        end else if (en_i) begin
            prod_q  <= prod_d;
            bias1_q <= bias_i;
            sum_q   <= sum_d;
            bias2_q <= bias1_q;
            dout_q  <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/color_matrix_nxn.sv
// N x N colour matrix top: stream handshake, valid/sof pipeline and
// double-buffered coefficient sets that swap at a start-of-frame beat.
module color_matrix_nxn
    import color_matrix_pkg::*;
#(
    parameter int DIM   = 3,
    parameter int IDW   = 10,
    parameter int MIDW  = 2,
    parameter int MFDW  = 14,
    parameter int ODW   = 8,
    parameter int ROUND = 1,
    localparam int MDW  = calc_mdw(MIDW, MFDW),
    localparam int BIW  = ODW + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   coef_wr,
    input  logic [DIM*DIM*MDW-1:0] coef_in,
    input  logic [DIM*BIW-1:0]     bias_in,
    output logic                   coef_pending,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_sof,
    input  logic [DIM*IDW-1:0]     s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic [DIM*ODW-1:0]     m_data
);

    localparam int CW = DIM * DIM * MDW;
    localparam int BV = DIM * BIW;

    function automatic logic [CW-1:0] ident_set();
        logic [CW-1:0] v;
        v = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                v[(r*DIM+c)*MDW +: MDW] = MDW'(identity_coef(r, c, MFDW));
            end
        end
        return v;
    endfunction

    localparam logic [CW-1:0] IDENT = ident_set();

    logic [CW-1:0] shadow_coef_q, shadow_coef_d, active_coef_q, active_coef_d;
    logic [BV-1:0] shadow_bias_q, shadow_bias_d, active_bias_q, active_bias_d;
    logic          pending_q, pending_d;
    logic [2:0]    vld_q, vld_d, sof_q, sof_d;
    logic          en, accept, apply;
    logic [CW-1:0] beat_coef;
    logic [BV-1:0] beat_bias;

    // Handshake and stall: every stage advances only when the output slot frees up.
    always_comb begin
        en        = !vld_q[2] || m_ready;
        accept    = s_valid && en;
        apply     = accept && s_sof && pending_q;
        beat_coef = apply ? shadow_coef_q : active_coef_q;
        beat_bias = apply ? shadow_bias_q : active_bias_q;
    end

    // Next state for coefficient sets and the valid/sof shift chain.
    always_comb begin
        shadow_coef_d = shadow_coef_q;
        shadow_bias_d = shadow_bias_q;
        active_coef_d = active_coef_q;
        active_bias_d = active_bias_q;
        pending_d     = pending_q;
        vld_d         = vld_q;
        sof_d         = sof_q;
        // The applying beat takes the pre-write shadow; a coincident write stays pending.
        if (apply) begin
            active_coef_d = shadow_coef_q;
            active_bias_d = shadow_bias_q;
            pending_d     = 1'b0;
        end
        if (coef_wr) begin
            shadow_coef_d = coef_in;
            shadow_bias_d = bias_in;
            pending_d     = 1'b1;
        end
        if (en) begin
            vld_d = {vld_q[1:0], accept};
            sof_d = {sof_q[1:0], accept && s_sof};
        end
    end

    // State registers; reset drops in-flight beats and restores identity.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_coef_q <= IDENT;
            shadow_bias_q <= '0;
            active_coef_q <= IDENT;
            active_bias_q <= '0;
            pending_q     <= 1'b0;
            vld_q         <= '0;
            sof_q         <= '0;
        end else begin
            shadow_coef_q <= shadow_coef_d;
            shadow_bias_q <= shadow_bias_d;
            active_coef_q <= active_coef_d;
            active_bias_q <= active_bias_d;
            pending_q     <= pending_d;
            vld_q         <= vld_d;
            sof_q         <= sof_d;
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        cm_row_dot #(
            .DIM   (DIM),
            .IDW   (IDW),
            .MIDW  (MIDW),
            .MFDW  (MFDW),
            .ODW   (ODW),
            .ROUND (ROUND)
        ) u_row (
            .clk    (clk),
            .rstn   (rstn),
            .en_i   (en),
            .din_i  (s_data),
            .coef_i (beat_coef[r*DIM*MDW +: DIM*MDW]),
            .bias_i (beat_bias[r*BIW +: BIW]),
            .dout_o (m_data[r*ODW +: ODW])
        );
    end

    assign s_ready      = en;
    assign m_valid      = vld_q[2];
    assign m_sof        = sof_q[2];
    assign coef_pending = pending_q;

endmodule

// File: tb/tb_color_matrix_nxn.sv
// Directed and backpressure bench for color_matrix_nxn at default parameters.
module tb_color_matrix_nxn;

    logic         clk = 1'b0;
    logic         rstn;
    logic         coef_wr;
    logic [143:0] coef_in;
    logic [26:0]  bias_in;
    logic         coef_pending;
    logic         s_valid, s_ready, s_sof;
    logic [29:0]  s_data;
    logic         m_valid, m_ready, m_sof;
    logic [23:0]  m_data;

    int n_total = 0;
    int n_bad   = 0;

    int wc [3][3];
    int wb [3];
    int mc [3][3];
    int mb [3];
    int ms [3][3];
    int msb [3];
    bit m_pend;

    logic [24:0] sbq [$];
    logic [23:0] last_out;
    logic        last_sof;
    int          out_cnt = 0;
    bit          bp_on = 0;
    bit          held_v = 0;
    logic [24:0] held;

    always #5 clk = ~clk;

    color_matrix_nxn dut (
        .clk          (clk),
        .rstn         (rstn),
        .coef_wr      (coef_wr),
        .coef_in      (coef_in),
        .bias_in      (bias_in),
        .coef_pending (coef_pending),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_sof        (s_sof),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sof        (m_sof),
        .m_data       (m_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] px3(input int a0, input int a1, input int a2);
        return {8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [29:0] din3(input int a0, input int a1, input int a2);
        return {10'(a2), 10'(a1), 10'(a0)};
    endfunction

    // Reference: Q2.14 coefficients, +0.5 LSB, floor shift by 16, bias, clamp to 0..255.
    function automatic logic [23:0] model_px(input logic [29:0] d);
        logic [23:0] res;
        longint      acc;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            acc = 0;
            for (int c = 0; c < 3; c++) begin
                acc = acc + longint'(d[c*10 +: 10]) * longint'(mc[r][c]);
            end
            acc = (acc + 32768) >>> 16;
            acc = acc + longint'(mb[r]);
            if (acc < 0)
                acc = 0;
            if (acc > 255)
                acc = 255;
            res[r*8 +: 8] = 8'(acc);
        end
        return res;
    endfunction

    task automatic set_ident(input int b0, input int b1, input int b2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                wc[r][c] = (r == c) ? 16384 : 0;
            end
        end
        wb[0] = b0;
        wb[1] = b1;
        wb[2] = b2;
    endtask

    task automatic pack_wr();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                coef_in[(r*3+c)*16 +: 16] = 16'(wc[r][c]);
            end
            bias_in[r*9 +: 9] = 9'(wb[r]);
        end
    endtask

    task automatic wr_coef();
        pack_wr();
        coef_wr = 1'b1;
        @(posedge clk);
        #1;
        coef_wr = 1'b0;
    endtask

    task automatic wait_accept();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_ready)
                return;
        end
        chk("accept_timeout", 64'(s_ready), 64'(1));
    endtask

    task automatic send(input logic [29:0] d, input logic sof);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        wait_accept();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0)
                break;
            @(negedge clk);
        end
        chk("drain_empty", 64'(sbq.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: always high unless the backpressure phase is running.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference coefficient sets and scoreboard push for every accepted beat.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    mc[r][c] = (r == c) ? 16384 : 0;
                    ms[r][c] = (r == c) ? 16384 : 0;
                end
                mb[r]  = 0;
                msb[r] = 0;
            end
            m_pend = 1'b0;
            sbq.delete();
        end else begin
            bit applied;
            chk("pending_track", 64'(coef_pending), 64'(m_pend));
            applied = 1'b0;
            if (s_valid && s_ready) begin
                if (s_sof && m_pend) begin
                    mc = ms;
                    mb = msb;
                    applied = 1'b1;
                end
                sbq.push_back({s_sof, model_px(s_data)});
            end
            if (coef_wr) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        ms[r][c] = int'($signed(coef_in[(r*3+c)*16 +: 16]));
                    end
                    msb[r] = int'($signed(bias_in[r*9 +: 9]));
                end
                m_pend = 1'b1;
            end else if (applied) begin
                m_pend = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard compare on transfer, hold check while stalled.
    always @(negedge clk) begin
        if (!rstn) begin
            held_v = 1'b0;
        end else begin
            logic [24:0] exp;
            if (held_v) begin
                chk("hold_valid", 64'(m_valid), 64'(1));
                chk("hold_data", 64'({m_sof, m_data}), 64'(held));
            end
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 64'(m_valid), 64'(0));
                end else begin
                    exp = sbq.pop_front();
                    chk("out_data", 64'(m_data), 64'(exp[23:0]));
                    chk("out_sof", 64'(m_sof), 64'(exp[24]));
                end
                last_out = m_data;
                last_sof = m_sof;
                out_cnt++;
            end
            held_v = m_valid && !m_ready;
            held   = {m_sof, m_data};
        end
    end

    initial begin
        int snap;
        rstn    = 1'b0;
        coef_wr = 1'b0;
        coef_in = '0;
        bias_in = '0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_sof", 64'(m_sof), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_pending", 64'(coef_pending), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Identity, rounding and saturation, plus 3-cycle latency.
        send(din3(512, 1023, 2), 1'b0);
        @(negedge clk);
        chk("lat_cycle1", 64'(m_valid), 64'(0));
        @(negedge clk);
        chk("lat_cycle2", 64'(m_valid), 64'(0));
        @(negedge clk);
        chk("lat_cycle3", 64'(m_valid), 64'(1));
        chk("ident_data", 64'(m_data), 64'(px3(128, 255, 1)));
        @(posedge clk);
        #1;

        // Negative coefficient clamps low.
        set_ident(0, 0, 0);
        wc[0][0] = -16384;
        wr_coef();
        chk("neg_pend_set", 64'(coef_pending), 64'(1));
        send(din3(300, 40, 100), 1'b1);
        drain();
        chk("neg_out", 64'(last_out), 64'(px3(0, 10, 25)));
        chk("neg_pend_clr", 64'(coef_pending), 64'(0));

        // Bias applied at an sof beat.
        set_ident(16, -16, 0);
        wr_coef();
        chk("bias_pend_set", 64'(coef_pending), 64'(1));
        send(din3(512, 8, 512), 1'b1);
        chk("bias_pend_fall", 64'(coef_pending), 64'(0));
        drain();
        chk("bias_out", 64'(last_out), 64'(px3(144, 0, 128)));

        // Mid-frame write is deferred to the next sof.
        set_ident(32, 0, 0);
        wr_coef();
        send(din3(512, 8, 512), 1'b0);
        drain();
        chk("defer_old", 64'(last_out), 64'(px3(144, 0, 128)));
        chk("defer_pend", 64'(coef_pending), 64'(1));
        send(din3(400, 400, 400), 1'b1);
        drain();
        chk("defer_new_sof", 64'(last_out), 64'(px3(132, 100, 100)));
        chk("defer_pend_clr", 64'(coef_pending), 64'(0));
        send(din3(400, 400, 400), 1'b0);
        drain();
        chk("defer_new_next", 64'(last_out), 64'(px3(132, 100, 100)));

        // Write coincident with the applying sof beat.
        set_ident(0, 64, 0);
        wr_coef();
        set_ident(0, 0, 0);
        pack_wr();
        coef_wr = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = din3(400, 400, 400);
        @(negedge clk);
        chk("coinc_accept", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
        coef_wr = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("coinc_pend", 64'(coef_pending), 64'(1));
        drain();
        chk("coinc_out", 64'(last_out), 64'(px3(100, 164, 100)));
        chk("coinc_sof", 64'(last_sof), 64'(1));
        send(din3(400, 400, 400), 1'b1);
        drain();
        chk("coinc_next", 64'(last_out), 64'(px3(100, 100, 100)));
        chk("coinc_pend_clr", 64'(coef_pending), 64'(0));

        // Random backpressure stream with two mid-stream coefficient writes.
        snap  = out_cnt;
        bp_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s_valid = 1'b1;
            s_sof   = (i % 37 == 0);
            s_data  = 30'($urandom());
            if (i == 300 || i == 600) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        wc[r][c] = int'($urandom_range(0, 32767)) - 16384;
                    end
                    wb[r] = int'($urandom_range(0, 511)) - 256;
                end
                pack_wr();
                coef_wr = 1'b1;
            end
            wait_accept();
            @(posedge clk);
            #1;
            coef_wr = 1'b0;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        bp_on   = 1'b0;
        drain();
        chk("bp_count", 64'(out_cnt - snap), 64'(1000));

        // Reset with three beats in flight.
        set_ident(50, 50, 50);
        wr_coef();
        send(din3(0, 0, 0), 1'b1);
        drain();
        chk("pre_rst_out", 64'(last_out), 64'(px3(50, 50, 50)));
        snap    = out_cnt;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_data = din3(100 * (k + 1), 100, 100);
            @(negedge clk);
            chk("rst_stream_acc", 64'(s_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("rst_inflight", 64'(m_valid), 64'(1));
        rstn = 1'b0;
        #1;
        chk("rst_mvalid_now", 64'(m_valid), 64'(0));
        chk("rst_pend_now", 64'(coef_pending), 64'(0));
        chk("rst_sready_now", 64'(s_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send(din3(512, 1023, 2), 1'b0);
        drain();
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_ident", 64'(last_out), 64'(px3(128, 255, 1)));
        chk("post_rst_count", 64'(out_cnt - snap), 64'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
